fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_wr_arbiter_rr_select.sv | 43 ++++
 rtl/fifo_wr_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write arbiter.
//   arb_state_e    : arbiter FSM encoding (IDLE=0, LOCKED=1)
//   DEF_NUM_REQ    : default number of write requesters
//   DEF_WIDTH      : default data width (FIFO write port width)
//   DEF_MAX_BURST  : default maximum beats per grant before forced release
package fifo_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BURST = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_select.sv
// rr_select: combinational round-robin pick.
// Finds the first set bit of req_i at or after ptr_i, wrapping modulo NUM_REQ.
//   req_i    : request vector
//   ptr_i    : starting position of the search
//   onehot_o : one-hot of the chosen requester (zero when none)
//   idx_o    : binary index of the chosen requester (zero when none)
//   any_o    : at least one request is set
module rr_select
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);

  // Walk offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    int       pos;
    logic [IDW-1:0] pos_idx;
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    pos      = 0;
    pos_idx  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = int'(ptr_i) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = IDW'(pos);
      if (req_i[pos_idx]) begin
        onehot_o          = '0;
        onehot_o[pos_idx] = 1'b1;
        idx_o             = pos_idx;
        any_o             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter letting NUM_REQ burst writers share
// one FIFO write port. A grant is held for a whole burst (until last, or a
// forced release after MAX_BURST beats). Data is passed straight through.
//   clk_i, clr_i  : clock, async active-high reset
//   req_valid_i   : per-requester beat valid
//   req_data_i    : flattened data, requester k at [k*WIDTH +: WIDTH]
//   req_last_i    : per-requester last beat of burst
//   req_ready_o   : per-requester beat accept
//   fifo_full_i   : FIFO full
//   fifo_wr_en_o  : FIFO write enable
//   fifo_wdata_o  : FIFO write data (zero when not writing)
//   grant_o       : one-hot current grant, zero when idle
//   grant_id_o    : binary index of current grant
//   overrun_o     : one-cycle pulse after a forced release
//
// state  | meaning
// IDLE   | no owner; arbitrate among valid requesters, grant on next edge
// LOCKED | grant_id_q owns the FIFO until last or MAX_BURST beats
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter  int NUM_REQ   = DEF_NUM_REQ,
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int MAX_BURST = DEF_MAX_BURST,
  localparam int IDW       = $clog2(NUM_REQ),
  localparam int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk_i,
  input  logic                     clr_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]       req_last_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic                     fifo_full_i,
  output logic                     fifo_wr_en_o,
  output logic [WIDTH-1:0]         fifo_wdata_o,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [IDW-1:0]           grant_id_o,
  output logic                     overrun_o
);

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic               overrun_q, overrun_d;

  logic [NUM_REQ-1:0] sel_onehot;
  logic [IDW-1:0]     sel_idx;
  logic               sel_any;
  logic               locked;
  logic               beat;
  logic [CW-1:0]      cnt_next;
  logic [IDW-1:0]     ptr_after;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_select (
    .req_i    (req_valid_i),
    .ptr_i    (rr_ptr_q),
    .onehot_o (sel_onehot),
    .idx_o    (sel_idx),
    .any_o    (sel_any)
  );

  assign locked = (state_q == ST_LOCKED);

  // Write path is pure pass-through of the owner; grant_q is already one-hot.
  always_comb begin
    beat         = locked & req_valid_i[grant_id_q] & ~fifo_full_i;
    req_ready_o  = (locked && !fifo_full_i) ? grant_q : '0;
    fifo_wr_en_o = beat;
    fifo_wdata_o = beat ? req_data_i[grant_id_q*WIDTH +: WIDTH] : '0;
  end

  assign cnt_next  = cnt_q + CW'(1);
  assign ptr_after = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    overrun_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          state_d    = ST_LOCKED;
          grant_d    = sel_onehot;
          grant_id_d = sel_idx;
          cnt_d      = '0;
        end
      end
      ST_LOCKED: begin
        if (beat) begin
          if (req_last_i[grant_id_q] || (cnt_next == CW'(MAX_BURST))) begin
            state_d    = ST_IDLE;
            rr_ptr_d   = ptr_after;
            grant_d    = '0;
            grant_id_d = '0;
            cnt_d      = '0;
            // A last beat landing exactly on the limit is a normal release.
            overrun_d  = ~req_last_i[grant_id_q];
          end else begin
            cnt_d = cnt_next;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      overrun_q  <= overrun_d;
    end
  end

  assign grant_o    = grant_q;
  assign grant_id_o = grant_id_q;
  assign overrun_o  = overrun_q;

endmodule
